// File: rtl/scic_mem_arbiter.sv
// Round-robin CPU / I/O arbiter for the shared SCIC memory with CPU lock; counters under SCIC_ARB_STATS_EN.
// Command registered one cycle after req, read data one cycle after command; a losing port just holds req.
module scic_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_cpu_cnt,
  output logic [15:0]       stat_io_cnt,
  output logic [15:0]       stat_conflict_cnt
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} lock_state_e;

  lock_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
  logic              r_last_io, w_last_io_nxt;
  logic              r_init;
  logic              r_cpu_gnt, r_io_gnt;
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_pend, r_io_pend;
  logic              r_cpu_rvalid, r_io_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata, r_io_rdata;
  logic              w_force, w_hold_lock;
  logic              w_cpu_elig, w_io_elig;
  logic              w_gnt_cpu, w_gnt_io;

  // Arbitration and lock next-state. r_init blanks the first edge after reset.
  always_comb begin
    w_force        = (r_state == ST_LOCKED) && (r_lock_cnt == CNT_W'(LOCK_MAX));
    w_hold_lock    = (r_state == ST_LOCKED) && cpu_lock && !w_force;
    w_cpu_elig     = cpu_req && !r_cpu_gnt && !r_init;
    w_io_elig      = io_req && !r_io_gnt && !w_hold_lock && !r_init;
    w_gnt_cpu      = 1'b0;
    w_gnt_io       = 1'b0;
    w_last_io_nxt  = r_last_io;
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;

    if (w_cpu_elig && w_io_elig) begin
      if (w_force || !r_last_io) begin
        w_gnt_io      = 1'b1;
        w_last_io_nxt = 1'b1;
      end else begin
        w_gnt_cpu     = 1'b1;
        w_last_io_nxt = 1'b0;
      end
    end else if (w_cpu_elig) begin
      w_gnt_cpu = 1'b1;
    end else if (w_io_elig) begin
      w_gnt_io = 1'b1;
    end

    case (r_state)
      ST_UNLOCKED: begin
        if (w_gnt_cpu && cpu_lock) begin
          w_state_nxt    = ST_LOCKED;
          w_lock_cnt_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (!cpu_lock || w_force) begin
          w_state_nxt    = ST_UNLOCKED;
          w_lock_cnt_nxt = '0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = ST_UNLOCKED;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_UNLOCKED;
      r_lock_cnt <= '0;
      r_last_io  <= 1'b1;
      r_init     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_last_io  <= w_last_io_nxt;
      r_init     <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cpu_gnt    <= 1'b0;
      r_io_gnt     <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_pend   <= 1'b0;
      r_io_pend    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_io_rvalid  <= 1'b0;
      r_cpu_rdata  <= '0;
      r_io_rdata   <= '0;
    end else begin
      r_cpu_gnt <= w_gnt_cpu;
      r_io_gnt  <= w_gnt_io;
      r_mem_en  <= w_gnt_cpu || w_gnt_io;
      if (w_gnt_cpu) begin
        r_mem_we    <= cpu_we;
        r_mem_addr  <= cpu_addr;
        r_mem_wdata <= cpu_wdata;
      end else if (w_gnt_io) begin
        r_mem_we    <= io_we;
        r_mem_addr  <= io_addr;
        r_mem_wdata <= io_wdata;
      end else begin
        r_mem_we <= 1'b0;
      end
      // Read tags follow the command by one cycle, matching the macro latency.
      r_cpu_pend   <= w_gnt_cpu && !cpu_we;
      r_io_pend    <= w_gnt_io && !io_we;
      r_cpu_rvalid <= r_cpu_pend;
      r_io_rvalid  <= r_io_pend;
      if (r_cpu_rvalid) r_cpu_rdata <= mem_rdata;
      if (r_io_rvalid)  r_io_rdata  <= mem_rdata;
    end
  end

  assign cpu_gnt    = r_cpu_gnt;
  assign io_gnt     = r_io_gnt;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_rvalid = r_cpu_rvalid;
  assign io_rvalid  = r_io_rvalid;
  assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : r_cpu_rdata;
  assign io_rdata   = r_io_rvalid ? mem_rdata : r_io_rdata;

`ifdef SCIC_ARB_STATS_EN
  logic [15:0] r_stat_cpu, r_stat_io, r_stat_conf;
  logic        w_conflict;

  assign w_conflict = (cpu_req && !r_cpu_gnt) || (io_req && !r_io_gnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_cpu  <= '0;
      r_stat_io   <= '0;
      r_stat_conf <= '0;
    end else begin
      if (r_cpu_gnt && (r_stat_cpu != 16'hFFFF))   r_stat_cpu  <= r_stat_cpu + 16'd1;
      if (r_io_gnt && (r_stat_io != 16'hFFFF))     r_stat_io   <= r_stat_io + 16'd1;
      if (w_conflict && (r_stat_conf != 16'hFFFF)) r_stat_conf <= r_stat_conf + 16'd1;
    end
  end

  assign stat_cpu_cnt      = r_stat_cpu;
  assign stat_io_cnt       = r_stat_io;
  assign stat_conflict_cnt = r_stat_conf;
`else
  assign stat_cpu_cnt      = 16'd0;
  assign stat_io_cnt       = 16'd0;
  assign stat_conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_scic_mem_arbiter.sv
// Scoreboard bench for scic_mem_arbiter: expected commands and read returns are queued by the stimulus
// and consumed by a negedge monitor; a behavioural single-port memory sits on the mem_* bus.
module tb_scic_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
  logic [7:0]  cpu_addr = 8'h00;
  logic [15:0] cpu_wdata = 16'h0000;
  logic        io_req = 1'b0, io_we = 1'b0;
  logic [7:0]  io_addr = 8'h00;
  logic [15:0] io_wdata = 16'h0000;
  logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
  logic [15:0] cpu_rdata, io_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] stat_cpu_cnt, stat_io_cnt, stat_conflict_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        port;   // 0 = CPU, 1 = IO
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } cmd_t;

  cmd_t        q_cmd[$];
  logic [15:0] q_cpu_rd[$];
  logic [15:0] q_io_rd[$];
  logic [15:0] mem [0:255];

  scic_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .LOCK_MAX(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stat_cpu_cnt(stat_cpu_cnt), .stat_io_cnt(stat_io_cnt), .stat_conflict_cnt(stat_conflict_cnt)
  );

  always #5 clock = ~clock;

  // Memory macro: one-cycle registered read, write on the command edge.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, i[7:0]};
    mem[8'h10] = 16'h1234;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clock);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata     <= mem[mem_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic port, input logic we, input logic [7:0] a, input logic [15:0] d);
    mk = {port, we, a, d};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    io_req  = 1'b0; io_we  = 1'b0; io_addr  = 8'h00; io_wdata  = 16'h0000;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    tick();
    check("rst_ctrl", 32'({cpu_gnt, io_gnt, mem_en, mem_we, cpu_rvalid, io_rvalid}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, io_rdata}), 32'd0);
    check("rst_stats", 32'(stat_cpu_cnt | stat_io_cnt | stat_conflict_cnt), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: every mem command and every read return must match the head of its queue.
  initial begin
    cmd_t        e;
    logic [15:0] d;
    logic        prev_c, prev_i;
    prev_c = 1'b0;
    prev_i = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_en) begin
        if (q_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: got addr %0h, expected no command", mem_addr);
        end else begin
          e = q_cmd.pop_front();
          check("cmd_cpu_gnt", 32'(cpu_gnt), 32'(e.port == 1'b0));
          check("cmd_io_gnt", 32'(io_gnt), 32'(e.port == 1'b1));
          check("cmd_we", 32'(mem_we), 32'(e.we));
          check("cmd_addr", 32'(mem_addr), 32'(e.addr));
          check("cmd_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end else if (cpu_gnt || io_gnt) begin
        checks++; errors++;
        $display("FAIL gnt_without_en: got gnt %0b%0b, expected 00", cpu_gnt, io_gnt);
      end
      if (cpu_gnt) check("b2b_cpu", 32'(prev_c), 32'd0);
      if (io_gnt)  check("b2b_io", 32'(prev_i), 32'd0);
      prev_c = cpu_gnt;
      prev_i = io_gnt;
      if (cpu_rvalid) begin
        if (q_cpu_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cpu_rvalid: got %0h, expected none", cpu_rdata);
        end else begin
          d = q_cpu_rd.pop_front();
          check("cpu_rdata", 32'(cpu_rdata), 32'(d));
        end
      end
      if (io_rvalid) begin
        if (q_io_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_io_rvalid: got %0h, expected none", io_rdata);
        end else begin
          d = q_io_rd.pop_front();
          check("io_rdata", 32'(io_rdata), 32'(d));
        end
      end
    end
  end

  initial begin
    // 1: single CPU read
    apply_reset();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    q_cmd.push_back(mk(1'b0, 1'b0, 8'h10, 16'h0000));
    q_cpu_rd.push_back(16'h1234);
    tick();
    check("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'h10);
    cpu_req = 1'b0;
    tick();
    check("t1_rvalid", 32'(cpu_rvalid), 32'd1);
    tick();

    // 2: continuous contention from reset -> strict alternation, statistics
    apply_reset();
    cpu_req = 1'b1; cpu_addr = 8'h20;
    io_req  = 1'b1; io_addr  = 8'h30;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        q_cmd.push_back(mk(1'b0, 1'b0, 8'h20, 16'h0000));
        q_cpu_rd.push_back(16'hA520);
      end else begin
        q_cmd.push_back(mk(1'b1, 1'b0, 8'h30, 16'h0000));
        q_io_rd.push_back(16'hA530);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t2_mem_en", 32'(mem_en), 32'd1);
      check("t2_cpu_gnt", 32'(cpu_gnt), 32'(k % 2 == 1));
    end
    cpu_req = 1'b0;
    io_req  = 1'b0;
    tick();
    tick();
`ifdef SCIC_ARB_STATS_EN
    check("t2_stat_cpu", 32'(stat_cpu_cnt), 32'd5);
    check("t2_stat_io", 32'(stat_io_cnt), 32'd5);
    check("t2_stat_conflict", 32'(stat_conflict_cnt), 32'd10);
`else
    check("t2_stat_cpu", 32'(stat_cpu_cnt), 32'd0);
    check("t2_stat_io", 32'(stat_io_cnt), 32'd0);
    check("t2_stat_conflict", 32'(stat_conflict_cnt), 32'd0);
`endif

    // 3: CPU write and I/O read of the same address in the same cycle
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 16'h00AA;
    io_req  = 1'b1; io_we  = 1'b0; io_addr  = 8'h05;
    q_cmd.push_back(mk(1'b0, 1'b1, 8'h05, 16'h00AA));
    q_cmd.push_back(mk(1'b1, 1'b0, 8'h05, 16'h0000));
    q_io_rd.push_back(16'h00AA);
    tick();
    check("t3_cpu_first", 32'({cpu_gnt, io_gnt}), 32'b10);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("t3_io_second", 32'({cpu_gnt, io_gnt}), 32'b01);
    io_req = 1'b0;
    tick();
    check("t3_io_rvalid", 32'(io_rvalid), 32'd1);
    tick();

    // 4: CPU lock held past LOCK_MAX with I/O waiting
    apply_reset();
    cpu_req = 1'b1; cpu_lock = 1'b1; cpu_addr = 8'h40;
    io_req  = 1'b1; io_addr  = 8'h50;
    for (int i = 0; i < 5; i++) begin
      q_cmd.push_back(mk(1'b0, 1'b0, 8'h40, 16'h0000));
      q_cpu_rd.push_back(16'hA540);
    end
    q_cmd.push_back(mk(1'b1, 1'b0, 8'h50, 16'h0000));
    q_io_rd.push_back(16'hA550);
    q_cmd.push_back(mk(1'b0, 1'b0, 8'h40, 16'h0000));
    q_cpu_rd.push_back(16'hA540);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("t4_io_gnt", 32'(io_gnt), 32'(k == 10));
      check("t4_cpu_gnt", 32'(cpu_gnt), 32'(((k % 2 == 1) && (k <= 9)) || (k == 11)));
    end
    idle_inputs();
    tick();
    tick();
    tick();

    // 5: reset arriving while a CPU read is in flight
    apply_reset();
    cpu_req = 1'b1; cpu_addr = 8'h10;
    q_cmd.push_back(mk(1'b0, 1'b0, 8'h10, 16'h0000));
    tick();
    check("t5_pre_gnt", 32'(cpu_gnt), 32'd1);
    cpu_req = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b1;
    cpu_req = 1'b1; cpu_addr = 8'h10;
    io_req  = 1'b1; io_addr  = 8'h60;
    tick();
    check("t5_rvalid_rst", 32'(cpu_rvalid), 32'd0);
    check("t5_outs_rst", 32'({cpu_gnt, io_gnt, mem_en, mem_addr}), 32'd0);
    tick();
    check("t5_rvalid_rst2", 32'(cpu_rvalid), 32'd0);
    reset = 1'b0;
    q_cmd.push_back(mk(1'b0, 1'b0, 8'h10, 16'h0000));
    q_cmd.push_back(mk(1'b1, 1'b0, 8'h60, 16'h0000));
    q_cpu_rd.push_back(16'h1234);
    q_io_rd.push_back(16'hA560);
    tick();
    check("t5_blank", 32'({cpu_gnt, io_gnt, mem_en}), 32'd0);
    tick();
    check("t5_first_cpu", 32'({cpu_gnt, io_gnt}), 32'b10);
    cpu_req = 1'b0;
    tick();
    check("t5_then_io", 32'({cpu_gnt, io_gnt}), 32'b01);
    io_req = 1'b0;
    tick();
    tick();
    tick();

    check("end_cmd_q", 32'(q_cmd.size()), 32'd0);
    check("end_cpu_rd_q", 32'(q_cpu_rd.size()), 32'd0);
    check("end_io_rd_q", 32'(q_io_rd.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scic_mem_arbiter.md
Name: scic_mem_arbiter

Overview:
Two-port arbiter sharing the SCIC single-port data/program memory between the CPU load/store/fetch port and the switch/LED I/O port. Round-robin arbitration, registered memory command outputs, one-cycle memory read latency, and an optional CPU lock for read-modify-write sequences. Sits between the SCIC core and the memory macro at top level.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, memory data width
LOCK_MAX, 8, max consecutive cycles cpu_lock may keep the I/O port out before forced release

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
cpu_req  in  1  CPU request; addr/we/wdata stable while high and ungranted
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_lock  in  1  CPU requests exclusive access after its grant
cpu_gnt  out  1  one-cycle pulse: CPU command issued this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
io_req, io_we, io_addr, io_wdata  in  1/1/ADDR_W/DATA_W  I/O port request, same rules as CPU
io_gnt, io_rvalid, io_rdata  out  1/1/DATA_W  I/O port grant/read return
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid cycle after mem_en with mem_we=0
stat_cpu_cnt, stat_io_cnt, stat_conflict_cnt  out  16 each  statistics (see Optional Feature)

Behaviour:
- Reset: all outputs 0; last_grant = IO (CPU wins first contention); lock inactive; lock counter 0; in-flight read tags cleared.
- Eligibility at each edge: req high AND not granted in the cycle just ending (no back-to-back grant to same port; max 1 command / 2 cycles per port).
- Decision at edge ending cycle N-1, effective cycle N: gnt_x=1, mem_en=1, mem_we/addr/wdata = port x inputs, all registered.
- Requester samples gnt in cycle N; must drop req or present a new request by end of cycle N+1.
- Contention (both eligible, no lock): grant port != last_grant; update last_grant to the granted port.
- Single eligible: grant it regardless of last_grant.
- No eligible: mem_en=0, gnt both 0, mem_addr/wdata hold previous values.
- Reads: rvalid_x=1 in cycle N+1 with rdata_x = mem_rdata; other port's rvalid=0, rdata holds. Writes produce no rvalid.
- Lock FSM, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED when CPU granted with cpu_lock=1.
  - LOCKED: I/O ineligible; CPU served whenever eligible; lock counter increments each cycle.
  - LOCKED -> UNLOCKED when cpu_lock=0, or counter reaches LOCK_MAX. On forced release, I/O gets the next grant if io_req high, even if cpu_req also high.
  - Counter clears on entering UNLOCKED.
- Simultaneous write from one port and read from the other: serialized in grant order; the read observes the write only if granted after it.
- Reset mid-operation: pending rvalid suppressed, no gnt or mem_en in the cycle after reset deasserts.

Optional Feature:
SCIC_ARB_STATS_EN
- Defined: stat_cpu_cnt / stat_io_cnt increment on each cpu_gnt / io_gnt.
- stat_conflict_cnt increments each cycle in which some port has req high but no gnt.
- All 16-bit, saturate at 0xFFFF, cleared by reset.
- Undefined: stat outputs tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset then cpu_req read addr 0x10 (mem holds 0x1234), io idle -> cpu_gnt cycle 1 after req, mem_addr=0x10, cpu_rvalid next cycle with cpu_rdata=0x1234.
- Both ports hold continuous read requests from reset -> grants alternate CPU, IO, CPU, IO; mem_en high every cycle; no back-to-back grant to either port.
- CPU writes 0x00AA to 0x05 while I/O requests a read of 0x05 in the same cycle -> CPU granted first; I/O rvalid returns 0x00AA.
- CPU issues grant with cpu_lock=1 and holds lock and reqs for 12 cycles with io_req high, LOCK_MAX=8 -> io_gnt withheld for 8 cycles, then io_gnt asserted.
- Assert reset in the cycle after a CPU read grant -> cpu_rvalid stays 0; all outputs 0 during reset; first post-reset contention goes to CPU.
- With SCIC_ARB_STATS_EN, run 10 alternating contention cycles -> stat_cpu_cnt=5, stat_io_cnt=5, stat_conflict_cnt=10; without the macro all stat outputs read 0.
